// File: rtl/cp0_timer_ctrl.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId plus a Count/Compare timer.
// Optional BadVAddr register (reg 8) and bad_vaddr input are enabled by defining CP0_BADVADDR_EN.
module cp0_timer_ctrl #(
    parameter int          NUM_HWINT = 6,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] PRID_VAL  = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 we,
    input  logic [31:0]          pc_in,
    input  logic                 bd,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]          bad_vaddr,
`endif
    output logic                 int_req,
    output logic [31:0]          epc,
    output logic [31:0]          rd_data
);

    localparam logic [7:0] DIV_LAST  = 8'(COUNT_DIV - 1);
    localparam logic [4:0] A_BADVA   = 5'd8;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_SR      = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;

    logic                 sr_ie, sr_exl;
    logic [NUM_HWINT-1:0] sr_im;
    logic                 c_bd, c_ti;
    logic [NUM_HWINT-1:0] c_ip;
    logic [4:0]           c_exc;
    logic [31:0]          epc_q, count_q, compare_q;
    logic [7:0]           presc_q;
    logic [NUM_HWINT-1:0] irq_line;
    logic                 int_term, wr_ok, cnt_wr, cmp_wr, cnt_tick;
    logic [31:0]          count_inc, sr_val, cause_val;
`ifdef CP0_BADVADDR_EN
    logic [31:0]          badva_q;
`endif

    // A victim in a delay slot restarts at the branch, one word earlier.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic slot);
        return slot ? 32'(pc - 32'd4) : pc;
    endfunction

    always_comb begin
        irq_line = hw_int;
        irq_line[NUM_HWINT-1] = hw_int[NUM_HWINT-1] | c_ti;
    end

    assign int_term  = (|(irq_line & sr_im)) & sr_ie & ~sr_exl;
    assign int_req   = int_term | (exc_valid & ~sr_exl);
    assign wr_ok     = we & ~int_req;
    assign cnt_wr    = wr_ok && (wr_addr == A_COUNT);
    assign cmp_wr    = wr_ok && (wr_addr == A_COMPARE);
    assign cnt_tick  = (presc_q == DIV_LAST);
    assign count_inc = 32'(count_q + 32'd1);
    assign epc       = epc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_ie     <= 1'b0;
            sr_exl    <= 1'b0;
            sr_im     <= '0;
            c_bd      <= 1'b0;
            c_ti      <= 1'b0;
            c_ip      <= '0;
            c_exc     <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            presc_q   <= '0;
        end else begin
            c_ip <= irq_line;
            if (int_req) begin
                sr_exl <= 1'b1;
                epc_q  <= restart_pc(pc_in, bd);
                c_bd   <= bd;
                c_exc  <= int_term ? 5'd0 : exc_code;
            end else if (eret) begin
                sr_exl <= 1'b0;
            end else if (we) begin
                if (wr_addr == A_SR) begin
                    sr_ie  <= wr_data[0];
                    sr_exl <= wr_data[1];
                    sr_im  <= wr_data[10 +: NUM_HWINT];
                end
                if (wr_addr == A_EPC)
                    epc_q <= wr_data;
            end
            // Timer: a Count load restarts the prescale period with no increment.
            if (cnt_wr) begin
                count_q <= wr_data;
                presc_q <= '0;
            end else if (cnt_tick) begin
                count_q <= count_inc;
                presc_q <= '0;
                if (count_inc == compare_q)
                    c_ti <= 1'b1;
            end else begin
                presc_q <= 8'(presc_q + 8'd1);
            end
            if (cmp_wr) begin
                compare_q <= wr_data;
                c_ti      <= 1'b0;
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    always_ff @(posedge clk) begin
        if (rst)
            badva_q <= '0;
        else if (int_req && !int_term && (exc_code == 5'd4 || exc_code == 5'd5))
            badva_q <= bad_vaddr;
    end
`endif

    always_comb begin
        sr_val = '0;
        sr_val[0] = sr_ie;
        sr_val[1] = sr_exl;
        sr_val[10 +: NUM_HWINT] = sr_im;
        cause_val = '0;
        cause_val[31] = c_bd;
        cause_val[30] = c_ti;
        cause_val[10 +: NUM_HWINT] = c_ip;
        cause_val[6:2] = c_exc;
        rd_data = '0;
        case (rd_addr)
`ifdef CP0_BADVADDR_EN
            A_BADVA:   rd_data = badva_q;
`else
            A_BADVA:   rd_data = '0;
`endif
            A_COUNT:   rd_data = count_q;
            A_COMPARE: rd_data = compare_q;
            A_SR:      rd_data = sr_val;
            A_CAUSE:   rd_data = cause_val;
            A_EPC:     rd_data = epc_q;
            A_PRID:    rd_data = PRID_VAL;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Directed bench for cp0_timer_ctrl (default parameters); covers CP0_BADVADDR_EN when defined.
module tb_cp0_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr, wr_addr, exc_code;
    logic [31:0] wr_data, pc_in;
    logic        we, bd, exc_valid, eret;
    logic [5:0]  hw_int;
    logic        int_req;
    logic [31:0] epc, rd_data;
`ifdef CP0_BADVADDR_EN
    logic [31:0] bad_vaddr;
`endif

    int checks = 0;
    int errors = 0;

    cp0_timer_ctrl dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .we(we), .pc_in(pc_in), .bd(bd),
        .exc_valid(exc_valid), .exc_code(exc_code), .hw_int(hw_int), .eret(eret),
`ifdef CP0_BADVADDR_EN
        .bad_vaddr(bad_vaddr),
`endif
        .int_req(int_req), .epc(epc), .rd_data(rd_data)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdc(input logic [4:0] a, input logic [31:0] exp, input string name);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic irqc(input logic exp, input string name);
        #1;
        chk(name, {31'd0, int_req}, {31'd0, exp});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; we = 1'b0;
        pc_in = '0; bd = 1'b0; exc_valid = 1'b0; exc_code = '0; hw_int = '0; eret = 1'b0;
`ifdef CP0_BADVADDR_EN
        bad_vaddr = '0;
`endif
        tick(); tick();
        irqc(1'b0, "rst_int_req");
        chk("rst_epc", epc, 32'h0);
        rdc(5'd12, 32'h0, "rst_sr");
        rdc(5'd13, 32'h0, "rst_cause");
        rdc(5'd15, 32'h0000_0001, "prid");
        rst = 1'b0;

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rdc(5'd12, 32'h0000_0401, "sr_write");
        hw_int = 6'b000001; pc_in = 32'h3010; bd = 1'b0;
        irqc(1'b1, "int_same_cycle");
        tick();
        irqc(1'b0, "int_masked_exl");
        rdc(5'd12, 32'h0000_0403, "entry_sr");
        chk("entry_epc", epc, 32'h3010);
        rdc(5'd13, 32'h0000_0400, "entry_cause");
        hw_int = '0;

        // Exception while EXL=1 is ignored
        exc_valid = 1'b1; exc_code = 5'd12; bd = 1'b1; pc_in = 32'h3020;
        irqc(1'b0, "exc_masked");
        tick();
        exc_valid = 1'b0; bd = 1'b0;
        chk("masked_epc", epc, 32'h3010);
        rdc(5'd12, 32'h0000_0403, "masked_sr");
        rdc(5'd13, 32'h0000_0000, "masked_cause");
        eret = 1'b1; tick(); eret = 1'b0;
        rdc(5'd12, 32'h0000_0401, "eret_sr");

        // Delay-slot exception
        exc_valid = 1'b1; exc_code = 5'd12; bd = 1'b1; pc_in = 32'h3020;
        irqc(1'b1, "exc_req");
        tick();
        exc_valid = 1'b0; bd = 1'b0;
        chk("ds_epc", epc, 32'h301C);
        rdc(5'd13, 32'h8000_0030, "ds_cause");
        rdc(5'd12, 32'h0000_0403, "ds_sr");
        eret = 1'b1; tick(); eret = 1'b0;

        // Entry beats eret and a same-cycle mtc0
        eret = 1'b1; hw_int = 6'b000001; pc_in = 32'h3040;
        we = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEE0;
        irqc(1'b1, "eret_int_req");
        tick();
        eret = 1'b0; hw_int = '0; we = 1'b0;
        rdc(5'd12, 32'h0000_0403, "eret_entry_sr");
        chk("eret_entry_epc", epc, 32'h3040);
        rdc(5'd13, 32'h0000_0400, "eret_entry_cause");
        eret = 1'b1; tick(); eret = 1'b0;
        mtc0(5'd14, 32'h0000_4000);
        chk("epc_mtc0", epc, 32'h0000_4000);

        // Timer: Compare=5, prescale 2
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        rdc(5'd9, 32'd0, "cnt_load0");
        repeat (9) tick();
        rdc(5'd9, 32'd4, "cnt_9cyc");
        rdc(5'd13, 32'h0000_0000, "ti_not_yet");
        irqc(1'b0, "timer_no_int");
        tick();
        rdc(5'd9, 32'd5, "cnt_10cyc");
        rdc(5'd13, 32'h4000_0000, "ti_set");
        pc_in = 32'h3100;
        irqc(1'b1, "timer_int");
        tick();
        rdc(5'd13, 32'h4000_8000, "timer_entry_cause");
        mtc0(5'd11, 32'h100);
        rdc(5'd13, 32'h0000_8000, "ti_cleared");

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        rdc(5'd9, 32'hFFFF_FFFF, "wrap_load");
        tick();
        rdc(5'd9, 32'hFFFF_FFFF, "wrap_hold");
        tick();
        rdc(5'd9, 32'h0, "wrap_zero");

        mtc0(5'd12, 32'hFFFF_FFFF);
        rdc(5'd12, 32'h0000_FC03, "sr_mask");

        // Reset mid-handler/mid-count
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        rdc(5'd9, 32'h0, "rst_count");
        rdc(5'd12, 32'h0, "rst_sr2");
        rdc(5'd13, 32'h0, "rst_cause2");
        chk("rst_epc2", epc, 32'h0);

        mtc0(5'd15, 32'h0);
        rdc(5'd15, 32'h0000_0001, "prid_ro");
        mtc0(5'd3, 32'h1234);
        rdc(5'd3, 32'h0, "unmapped");

        // Address-error entry: BadVAddr capture
        exc_valid = 1'b1; exc_code = 5'd4; pc_in = 32'h3200;
`ifdef CP0_BADVADDR_EN
        bad_vaddr = 32'h0000_1003;
`endif
        tick();
        exc_valid = 1'b0;
        rdc(5'd13, 32'h0000_0010, "adel_cause");
`ifdef CP0_BADVADDR_EN
        rdc(5'd8, 32'h0000_1003, "badvaddr");
`else
        rdc(5'd8, 32'h0, "reg8_zero");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
